// File: rtl/axi4l_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port among NM masters.
// The write (AW/W/B) and read (AR/R) paths each run their own FSM and carry one
// transaction at a time. Grants are registered, so no master valid reaches its
// own ready in the same cycle. Each last-grant pointer advances only when a
// transaction completes.
module axi4l_rr_arbiter #(
   parameter int NM = 3,
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic               clk,
   input  logic               rst,
   // master-side write address / data / response
   input  logic [NM-1:0]      m_awvalid,
   output logic [NM-1:0]      m_awready,
   input  logic [NM*AW-1:0]   m_awaddr,
   input  logic [NM*3-1:0]    m_awprot,
   input  logic [NM-1:0]      m_wvalid,
   output logic [NM-1:0]      m_wready,
   input  logic [NM*DW-1:0]   m_wdata,
   input  logic [NM*DW/8-1:0] m_wstrb,
   output logic [NM-1:0]      m_bvalid,
   input  logic [NM-1:0]      m_bready,
   output logic [NM*2-1:0]    m_bresp,
   // master-side read address / data
   input  logic [NM-1:0]      m_arvalid,
   output logic [NM-1:0]      m_arready,
   input  logic [NM*AW-1:0]   m_araddr,
   input  logic [NM*3-1:0]    m_arprot,
   output logic [NM-1:0]      m_rvalid,
   input  logic [NM-1:0]      m_rready,
   output logic [NM*DW-1:0]   m_rdata,
   output logic [NM*2-1:0]    m_rresp,
   // slave side
   output logic               s_awvalid,
   input  logic               s_awready,
   output logic [AW-1:0]      s_awaddr,
   output logic [2:0]         s_awprot,
   output logic               s_wvalid,
   input  logic               s_wready,
   output logic [DW-1:0]      s_wdata,
   output logic [DW/8-1:0]    s_wstrb,
   input  logic               s_bvalid,
   output logic               s_bready,
   input  logic [1:0]         s_bresp,
   output logic               s_arvalid,
   input  logic               s_arready,
   output logic [AW-1:0]      s_araddr,
   output logic [2:0]         s_arprot,
   input  logic               s_rvalid,
   output logic               s_rready,
   input  logic [DW-1:0]      s_rdata,
   input  logic [1:0]         s_rresp,
   // current owners
   output logic [NM-1:0]      wr_gnt,
   output logic [NM-1:0]      rd_gnt
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = DW / 8;
   localparam logic [NM-1:0] ONE_NM = {{(NM-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_e;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;

   // first requester found scanning upward from last+1, wrapping at NM
   function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] req, input logic [IW-1:0] last);
      logic [IW-1:0] idx;
      logic          found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= NM; k++) begin
         idx = IW'((int'(last) + k) % NM);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   wr_state_e     wr_state_q, wr_state_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d, last_wr_q, last_wr_d;
   logic [NM-1:0] wr_gnt_q, wr_gnt_d;
   logic          aw_done_q, aw_done_d, w_done_q, w_done_d;

   rd_state_e     rd_state_q, rd_state_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d, last_rd_q, last_rd_d;
   logic [NM-1:0] rd_gnt_q, rd_gnt_d;

   logic          aw_fire_s, w_fire_s, ar_fire_s;

   assign aw_fire_s = s_awvalid & s_awready;
   assign w_fire_s  = s_wvalid & s_wready;
   assign ar_fire_s = s_arvalid & s_arready;
   assign wr_gnt    = wr_gnt_q;
   assign rd_gnt    = rd_gnt_q;

   // write FSM next state: arbitrate in idle, track AW/W handshakes, finish on B
   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_gnt_d   = wr_gnt_q;
      last_wr_d  = last_wr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      case (wr_state_q)
         W_IDLE: begin
            if (|m_awvalid) begin
               wr_idx_d   = rr_pick(m_awvalid, last_wr_q);
               wr_gnt_d   = ONE_NM << wr_idx_d;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_state_d = W_ADDR;
            end else begin
               wr_gnt_d   = {NM{1'b0}};
            end
         end
         W_ADDR: begin
            if ((aw_done_q | aw_fire_s) && (w_done_q | w_fire_s)) begin
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_state_d = W_RESP;
            end else begin
               aw_done_d  = aw_done_q | aw_fire_s;
               w_done_d   = w_done_q | w_fire_s;
            end
         end
         W_RESP: begin
            if (s_bvalid && m_bready[wr_idx_q]) begin
               last_wr_d  = wr_idx_q;
               wr_gnt_d   = {NM{1'b0}};
               wr_state_d = W_IDLE;
            end else begin
               wr_state_d = W_RESP;
            end
         end
         default: begin
            wr_gnt_d   = {NM{1'b0}};
            wr_state_d = W_IDLE;
         end
      endcase
   end

   // read FSM next state: arbitrate in idle, finish address on AR, finish on R
   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      rd_gnt_d   = rd_gnt_q;
      last_rd_d  = last_rd_q;
      case (rd_state_q)
         R_IDLE: begin
            if (|m_arvalid) begin
               rd_idx_d   = rr_pick(m_arvalid, last_rd_q);
               rd_gnt_d   = ONE_NM << rd_idx_d;
               rd_state_d = R_ADDR;
            end else begin
               rd_gnt_d   = {NM{1'b0}};
            end
         end
         R_ADDR: begin
            if (ar_fire_s) begin
               rd_state_d = R_DATA;
            end else begin
               rd_state_d = R_ADDR;
            end
         end
         R_DATA: begin
            if (s_rvalid && m_rready[rd_idx_q]) begin
               last_rd_d  = rd_idx_q;
               rd_gnt_d   = {NM{1'b0}};
               rd_state_d = R_IDLE;
            end else begin
               rd_state_d = R_DATA;
            end
         end
         default: begin
            rd_gnt_d   = {NM{1'b0}};
            rd_state_d = R_IDLE;
         end
      endcase
   end

   // state registers for both FSMs; reset abandons any in-flight transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         wr_idx_q   <= {IW{1'b0}};
         wr_gnt_q   <= {NM{1'b0}};
         last_wr_q  <= LAST_RST;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         rd_state_q <= R_IDLE;
         rd_idx_q   <= {IW{1'b0}};
         rd_gnt_q   <= {NM{1'b0}};
         last_rd_q  <= LAST_RST;
      end else begin
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_gnt_q   <= wr_gnt_d;
         last_wr_q  <= last_wr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_gnt_q   <= rd_gnt_d;
         last_rd_q  <= last_rd_d;
      end
   end

   // write channel routing between the granted master and the slave
   always_comb begin
      m_awready = {NM{1'b0}};
      m_wready  = {NM{1'b0}};
      m_bvalid  = {NM{1'b0}};
      m_bresp   = {(NM*2){1'b0}};
      s_awvalid = 1'b0;
      s_awaddr  = {AW{1'b0}};
      s_awprot  = 3'b000;
      s_wvalid  = 1'b0;
      s_wdata   = {DW{1'b0}};
      s_wstrb   = {SW{1'b0}};
      s_bready  = 1'b0;
      case (wr_state_q)
         W_ADDR: begin
            if (!aw_done_q) begin
               s_awvalid           = m_awvalid[wr_idx_q];
               s_awaddr            = m_awaddr[wr_idx_q*AW +: AW];
               s_awprot            = m_awprot[wr_idx_q*3 +: 3];
               m_awready[wr_idx_q] = s_awready;
            end else begin
               s_awvalid           = 1'b0;
            end
            if (!w_done_q) begin
               s_wvalid            = m_wvalid[wr_idx_q];
               s_wdata             = m_wdata[wr_idx_q*DW +: DW];
               s_wstrb             = m_wstrb[wr_idx_q*SW +: SW];
               m_wready[wr_idx_q]  = s_wready;
            end else begin
               s_wvalid            = 1'b0;
            end
         end
         W_RESP: begin
            s_bready                  = m_bready[wr_idx_q];
            m_bvalid[wr_idx_q]        = s_bvalid;
            m_bresp[wr_idx_q*2 +: 2]  = s_bresp;
         end
         default: begin
            s_bready = 1'b0;
         end
      endcase
   end

   // read channel routing between the granted master and the slave
   always_comb begin
      m_arready = {NM{1'b0}};
      m_rvalid  = {NM{1'b0}};
      m_rdata   = {(NM*DW){1'b0}};
      m_rresp   = {(NM*2){1'b0}};
      s_arvalid = 1'b0;
      s_araddr  = {AW{1'b0}};
      s_arprot  = 3'b000;
      s_rready  = 1'b0;
      case (rd_state_q)
         R_ADDR: begin
            s_arvalid           = m_arvalid[rd_idx_q];
            s_araddr            = m_araddr[rd_idx_q*AW +: AW];
            s_arprot            = m_arprot[rd_idx_q*3 +: 3];
            m_arready[rd_idx_q] = s_arready;
         end
         R_DATA: begin
            s_rready                   = m_rready[rd_idx_q];
            m_rvalid[rd_idx_q]         = s_rvalid;
            m_rdata[rd_idx_q*DW +: DW] = s_rdata;
            m_rresp[rd_idx_q*2 +: 2]   = s_rresp;
         end
         default: begin
            s_rready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// Directed bench for axi4l_rr_arbiter: a reactive slave model plus per-channel
// scoreboards. Expected transactions are queued in expected grant order when the
// stimulus is driven and are checked/popped when the slave-side handshakes occur.
module tb_axi4l_rr_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk, rst;
   logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
   logic [NM*AW-1:0]  m_awaddr, m_araddr;
   logic [NM*3-1:0]   m_awprot, m_arprot;
   logic [NM*DW-1:0]  m_wdata, m_rdata;
   logic [NM*4-1:0]   m_wstrb;
   logic [NM*2-1:0]   m_bresp, m_rresp;
   logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic              s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AW-1:0]     s_awaddr, s_araddr;
   logic [2:0]        s_awprot, s_arprot;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic [3:0]        s_wstrb;
   logic [1:0]        s_bresp, s_rresp;
   logic [NM-1:0]     wr_gnt, rd_gnt;

   axi4l_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
   );

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t wq[$];
   txn_t rq[$];
   int   checks = 0;
   int   errors = 0;
   int   aw_stall = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NM-1:0] oh(input int m);
      logic [NM-1:0] one;
      one = 3'b001;
      oh  = one << m;
   endfunction

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      rdata_of = a ^ 32'hC0DE_5A00;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_aw(input int m, input logic [31:0] a);
      m_awaddr[m*AW +: AW] = a;
      m_awprot[m*3 +: 3]   = 3'(m);
      m_awvalid[m]         = 1'b1;
   endtask

   task automatic drive_w(input int m, input logic [31:0] d);
      m_wdata[m*DW +: DW] = d;
      m_wstrb[m*4 +: 4]   = 4'hF;
      m_wvalid[m]         = 1'b1;
   endtask

   task automatic wr_req(input int m, input logic [31:0] a, input logic [31:0] d);
      wq.push_back('{m: m, addr: a, data: d});
      drive_aw(m, a);
      drive_w(m, d);
   endtask

   task automatic rd_req(input int m, input logic [31:0] a);
      rq.push_back('{m: m, addr: a, data: rdata_of(a)});
      m_araddr[m*AW +: AW] = a;
      m_arprot[m*3 +: 3]   = 3'(m);
      m_arvalid[m]         = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget && (wq.size() + rq.size()) != 0; n++) cyc();
      chk("drain_timeout", 64'(wq.size() + rq.size()), 64'd0);
   endtask

   // slave model, master valid retirement and scoreboard compare
   initial begin : env
      logic [NM-1:0] maw_f, mw_f, mar_f;
      logic          aw_f, w_f, b_f, ar_f, r_f, got_aw, got_w;
      logic [31:0]   cap_aw, cap_ar;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
      got_aw = 1'b0; got_w = 1'b0; cap_aw = 32'h0; cap_ar = 32'h0;
      forever begin
         @(negedge clk);
         maw_f = m_awvalid & m_awready;
         mw_f  = m_wvalid & m_wready;
         mar_f = m_arvalid & m_arready;
         aw_f  = s_awvalid & s_awready;
         w_f   = s_wvalid & s_wready;
         b_f   = s_bvalid & s_bready;
         ar_f  = s_arvalid & s_arready;
         r_f   = s_rvalid & s_rready;
         if (!rst) begin
            if (aw_f) begin
               chk("aw_expected", 64'(wq.size() > 0), 64'd1);
               if (wq.size() > 0) begin
                  chk("s_awaddr", 64'(s_awaddr), 64'(wq[0].addr));
                  chk("s_awprot", 64'(s_awprot), 64'(wq[0].m));
                  chk("aw_wr_gnt", 64'(wr_gnt), 64'(oh(wq[0].m)));
               end
            end
            if (w_f && wq.size() > 0) begin
               chk("s_wdata", 64'(s_wdata), 64'(wq[0].data));
               chk("s_wstrb", 64'(s_wstrb), 64'h0F);
            end
            if (b_f) begin
               chk("b_expected", 64'(wq.size() > 0), 64'd1);
               if (wq.size() > 0) begin
                  chk("m_bvalid", 64'(m_bvalid), 64'(oh(wq[0].m)));
                  chk("m_bresp", 64'(m_bresp), 64'(wq[0].addr[5:4]) << (2 * wq[0].m));
                  void'(wq.pop_front());
               end
            end
            if (ar_f) begin
               chk("ar_expected", 64'(rq.size() > 0), 64'd1);
               if (rq.size() > 0) begin
                  chk("s_araddr", 64'(s_araddr), 64'(rq[0].addr));
                  chk("ar_rd_gnt", 64'(rd_gnt), 64'(oh(rq[0].m)));
               end
            end
            if (r_f) begin
               chk("r_expected", 64'(rq.size() > 0), 64'd1);
               if (rq.size() > 0) begin
                  chk("m_rvalid", 64'(m_rvalid), 64'(oh(rq[0].m)));
                  chk("m_rdata", 64'(m_rdata[rq[0].m*DW +: DW]), 64'(rq[0].data));
                  chk("m_rresp", 64'(m_rresp), 64'(rq[0].addr[9:8]) << (2 * rq[0].m));
                  void'(rq.pop_front());
               end
            end
         end
         if (aw_f) cap_aw = s_awaddr;
         if (ar_f) cap_ar = s_araddr;
         @(posedge clk);
         #1;
         if (rst) begin
            s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
            s_arready = 1'b0; s_rvalid = 1'b0;
            got_aw = 1'b0; got_w = 1'b0; aw_stall = 0;
         end else begin
            m_awvalid = m_awvalid & ~maw_f;
            m_wvalid  = m_wvalid & ~mw_f;
            m_arvalid = m_arvalid & ~mar_f;
            if (aw_f) got_aw = 1'b1;
            if (w_f)  got_w  = 1'b1;
            if (b_f)  s_bvalid = 1'b0;
            if (!s_bvalid && got_aw && got_w) begin
               s_bvalid = 1'b1;
               s_bresp  = cap_aw[5:4];
               got_aw   = 1'b0;
               got_w    = 1'b0;
            end
            if (aw_stall > 0) begin
               s_awready = 1'b0;
               aw_stall--;
            end else begin
               s_awready = !got_aw;
            end
            s_wready = !got_w;
            if (r_f) s_rvalid = 1'b0;
            if (ar_f) begin
               s_rvalid = 1'b1;
               s_rdata  = rdata_of(cap_ar);
               s_rresp  = cap_ar[9:8];
            end
            s_arready = !s_rvalid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1;
      m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
      m_awaddr = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0;
      m_wdata = '0; m_wstrb = '0;
      m_bready = 3'b111; m_rready = 3'b111;
      repeat (3) cyc();

      // reset state
      chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
      chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
      chk("rst_m_readies", 64'({m_awready, m_wready, m_arready}), 64'd0);
      chk("rst_m_valids", 64'({m_bvalid, m_rvalid}), 64'd0);
      chk("rst_s_ctrl", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 64'd0);
      rst = 1'b0;
      cyc();

      // 1: single m0 write, one-cycle grant latency, no combinational ready
      wr_req(0, 32'h10, 32'hDEAD_BEEF);
      #1;
      chk("t1_no_comb_gnt", 64'(wr_gnt), 64'd0);
      chk("t1_no_comb_ready", 64'({m_awready, s_awvalid}), 64'd0);
      cyc();
      chk("t1_wr_gnt", 64'(wr_gnt), 64'b001);
      chk("t1_s_awvalid", 64'(s_awvalid), 64'd1);
      chk("t1_s_awaddr", 64'(s_awaddr), 64'h10);
      wait_done(40);
      chk("t1_gnt_clear", 64'(wr_gnt), 64'd0);

      // 2: three simultaneous readers served 0,1,2
      rd_req(0, 32'h100);
      rd_req(1, 32'h200);
      rd_req(2, 32'h300);
      cyc();
      chk("t2_rd_gnt_first", 64'(rd_gnt), 64'b001);
      wait_done(60);

      // 3: m1 streams writes, m2 requests once -> grant order 1,2,1
      wr_req(1, 32'h1000, 32'h1111_0001);
      wr_req(2, 32'h2000, 32'h2222_0002);
      for (int n = 0; n < 40 && (m_awvalid[1] || m_wvalid[1]); n++) cyc();
      chk("t3_m1_accepted", 64'({m_awvalid[1], m_wvalid[1]}), 64'd0);
      wr_req(1, 32'h1004, 32'h1111_0003);
      wait_done(60);

      // 4: concurrent read (m0) and write (m1) on different masters
      rd_req(0, 32'h4);
      wr_req(1, 32'h8, 32'h0808_0808);
      cyc();
      chk("t4_rd_gnt", 64'(rd_gnt), 64'b001);
      chk("t4_wr_gnt", 64'(wr_gnt), 64'b010);
      wait_done(40);

      // 5: W ahead of AW, slave AW stall, competing m0 request held off
      drive_w(2, 32'h5555_AAAA);
      for (int n = 0; n < 3; n++) begin
         cyc();
         chk("t5_no_gnt_w_only", 64'({wr_gnt, m_wready}), 64'd0);
      end
      aw_stall = 6;
      wq.push_back('{m: 2, addr: 32'h3000, data: 32'h5555_AAAA});
      drive_aw(2, 32'h3000);
      cyc();
      chk("t5_wr_gnt", 64'(wr_gnt), 64'b100);
      wr_req(0, 32'h3004, 32'h0000_3004);
      for (int n = 0; n < 4; n++) begin
         cyc();
         chk("t5_gnt_held", 64'(wr_gnt), 64'b100);
         chk("t5_aw_held", 64'({s_awvalid, s_awaddr}), {31'd0, 1'b1, 32'h3000});
         chk("t5_m0_blocked", 64'({m_awready[0], m_wready[0]}), 64'd0);
      end
      wait_done(60);

      // 6: reset during W_RESP with bvalid pending, pointer returns to m0-first
      m_bready = 3'b011;
      wr_req(2, 32'h4000, 32'h4444_4444);
      for (int n = 0; n < 30 && !m_bvalid[2]; n++) cyc();
      chk("t6_in_resp", 64'({wr_gnt, m_bvalid}), {58'd0, 3'b100, 3'b100});
      rst = 1'b1;
      cyc();
      chk("t6_rst_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
      chk("t6_rst_m", 64'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid}), 64'd0);
      chk("t6_rst_s", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 64'd0);
      rst = 1'b0;
      wq.delete();
      rq.delete();
      m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
      m_bready = 3'b111;
      wr_req(0, 32'h5000, 32'h5000_0000);
      wr_req(1, 32'h5004, 32'h5004_0000);
      cyc();
      chk("t6_m0_first", 64'(wr_gnt), 64'b001);
      wait_done(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
